acc_axi_rd_arbiter: RTL and testbench

- Shares the single AXI4 read channel of the DNN accelerator's user AXI master port (64-bit data, 4-bit arlen, 1-bit id) between two internal read engines: m0 = weight fetch, m1 = feature-map fetch.
- Round-robin arbitration, one outstanding burst at a time.
- Sits inside the accelerator top, between the fetch engines and the user_axi_ar*/r* ports.
- Write channel is untouched.

---
 rtl/acc_axi_pkg.sv | 15 +
 rtl/acc_rr_pick2.sv | 13 +
 rtl/acc_axi_rd_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_acc_axi_rd_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_axi_pkg.sv
// Shared encodings for the accelerator AXI read arbiter: FSM states and the
// AXI burst/response codes used by the fetch engines.
package acc_axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/acc_rr_pick2.sv
// Two-way round-robin picker: a lone requester always wins; when both
// request, the pointer decides.
module acc_rr_pick2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic       gnt_idx,
  output logic       gnt_valid
);

  assign gnt_valid = |valid;
  assign gnt_idx   = (valid == 2'b11) ? ptr : valid[1];

endmodule

// File: rtl/acc_axi_rd_arbiter.sv
// Shares the accelerator's single AXI4 read channel between weight fetch (m0)
// and feature-map fetch (m1); one burst in flight. ACC_ARB_STAT_EN adds counters.
module acc_axi_rd_arbiter
  import acc_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 4
) (
  input  logic              cpu_clk,
  input  logic              cpu_reset,

  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [LEN_W-1:0]  m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  output logic              m0_rvalid,
  input  logic              m0_rready,

  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [LEN_W-1:0]  m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  output logic              m1_rvalid,
  input  logic              m1_rready,

  output logic [ADDR_W-1:0] axi_araddr,
  output logic [LEN_W-1:0]  axi_arlen,
  output logic [2:0]        axi_arsize,
  output logic [1:0]        axi_arburst,
  output logic              axi_arid,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  input  logic [DATA_W-1:0] axi_rdata,
  input  logic [1:0]        axi_rresp,
  input  logic              axi_rlast,
  input  logic              axi_rid,
  input  logic              axi_rvalid,
  output logic              axi_rready,

  output logic              busy,
  output logic              proto_err
`ifdef ACC_ARB_STAT_EN
  ,
  output logic [31:0]       grant_cnt0,
  output logic [31:0]       grant_cnt1,
  output logic [31:0]       stall_cnt
`endif
);

  // state | meaning
  // IDLE  | no burst owned; grant on any mX_arvalid
  // ADDR  | AR presented from registers until axi_arready
  // DATA  | R beats routed to owner until the rlast handshake

  state_t             state, state_nxt;
  logic               ptr;
  logic               owner;
  logic [LEN_W-1:0]   beat_cnt;
  logic [ADDR_W-1:0]  ar_addr;
  logic [LEN_W-1:0]   ar_len;
  logic [2:0]         ar_size;
  logic [1:0]         ar_burst;

  logic               gnt_idx;
  logic               gnt_valid;
  logic               capture;
  logic               rdy_sel;
  logic               ar_hs;
  logic               r_hs;
  logic               err_set;

  acc_rr_pick2 u_pick (
    .valid     ({m1_arvalid, m0_arvalid}),
    .ptr       (ptr),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign rdy_sel = owner ? m1_rready : m0_rready;
  assign ar_hs   = (state == ADDR) & axi_arready;
  assign r_hs    = (state == DATA) & axi_rvalid & rdy_sel;

  // Any beat outside DATA is stray; inside DATA the count, rlast and id must agree.
  assign err_set = ((state != DATA) & axi_rvalid) |
                   (r_hs & ((axi_rlast & (beat_cnt != ar_len)) |
                            (~axi_rlast & (beat_cnt == ar_len)) |
                            (axi_rid != owner)));

  always_ff @(posedge cpu_clk or posedge cpu_reset) begin
    if (cpu_reset) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    capture     = 1'b0;
    m0_arready  = 1'b0;
    m1_arready  = 1'b0;
    axi_arvalid = 1'b0;
    axi_rready  = 1'b0;
    m0_rvalid   = 1'b0;
    m1_rvalid   = 1'b0;
    m0_rlast    = 1'b0;
    m1_rlast    = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          capture   = 1'b1;
          state_nxt = ADDR;
          if (gnt_idx) m1_arready = 1'b1;
          else         m0_arready = 1'b1;
        end
      end
      ADDR: begin
        axi_arvalid = 1'b1;
        if (axi_arready) state_nxt = DATA;
      end
      DATA: begin
        axi_rready = rdy_sel;
        if (owner) begin
          m1_rvalid = axi_rvalid;
          m1_rlast  = axi_rlast;
        end else begin
          m0_rvalid = axi_rvalid;
          m0_rlast  = axi_rlast;
        end
        if (r_hs && axi_rlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      ptr       <= 1'b0;
      owner     <= 1'b0;
      beat_cnt  <= '0;
      ar_addr   <= '0;
      ar_len    <= '0;
      ar_size   <= '0;
      ar_burst  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (capture) begin
        owner    <= gnt_idx;
        ar_addr  <= gnt_idx ? m1_araddr  : m0_araddr;
        ar_len   <= gnt_idx ? m1_arlen   : m0_arlen;
        ar_size  <= gnt_idx ? m1_arsize  : m0_arsize;
        ar_burst <= gnt_idx ? m1_arburst : m0_arburst;
      end
      if (ar_hs)     beat_cnt <= '0;
      else if (r_hs) beat_cnt <= beat_cnt + 1'b1;
      if (r_hs && axi_rlast) ptr <= ~owner;
      if (err_set) proto_err <= 1'b1;
    end
  end

  assign axi_araddr  = ar_addr;
  assign axi_arlen   = ar_len;
  assign axi_arsize  = ar_size;
  assign axi_arburst = ar_burst;
  assign axi_arid    = owner;

  // Data and response fan out to both engines; only rvalid/rlast qualify them.
  assign m0_rdata = axi_rdata;
  assign m1_rdata = axi_rdata;
  assign m0_rresp = axi_rresp;
  assign m1_rresp = axi_rresp;

  assign busy = (state != IDLE);

`ifdef ACC_ARB_STAT_EN
  always_ff @(posedge cpu_clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      stall_cnt  <= '0;
    end else begin
      if (ar_hs && !owner) grant_cnt0 <= grant_cnt0 + 32'd1;
      if (ar_hs && owner)  grant_cnt1 <= grant_cnt1 + 32'd1;
      if ((state == DATA) && axi_rvalid && !axi_rready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_acc_axi_rd_arbiter.sv
// Directed bench for acc_axi_rd_arbiter: a table of complete bursts plus
// hand-written sequences for AR stall, R back-pressure, protocol error and reset.
module tb_acc_axi_rd_arbiter;
  import acc_axi_pkg::*;

  logic        cpu_clk = 1'b0;
  logic        cpu_reset;
  logic [31:0] m0_araddr, m1_araddr;
  logic [3:0]  m0_arlen, m1_arlen;
  logic [2:0]  m0_arsize, m1_arsize;
  logic [1:0]  m0_arburst, m1_arburst;
  logic        m0_arvalid, m1_arvalid;
  logic        m0_arready, m1_arready;
  logic [63:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_rresp, m1_rresp;
  logic        m0_rlast, m1_rlast, m0_rvalid, m1_rvalid;
  logic        m0_rready, m1_rready;
  logic [31:0] axi_araddr;
  logic [3:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_arid, axi_arvalid, axi_arready;
  logic [63:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast, axi_rid, axi_rvalid, axi_rready;
  logic        busy, proto_err;
`ifdef ACC_ARB_STAT_EN
  logic [31:0] grant_cnt0, grant_cnt1, stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  acc_axi_rd_arbiter dut (
    .cpu_clk(cpu_clk), .cpu_reset(cpu_reset),
    .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arid(axi_arid), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rid(axi_rid), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready), .busy(busy), .proto_err(proto_err)
`ifdef ACC_ARB_STAT_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .stall_cnt(stall_cnt)
`endif
  );

  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        v0;
    logic        v1;
    logic [3:0]  len;
    logic        exp_id;
    logic [31:0] a0;
    logic [31:0] a1;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [63:0] pat(input logic id, input int b);
    return 64'hA5A5_0000_0000_0000 | (64'(id) << 16) | 64'(b);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge cpu_clk);
    #2;
  endtask

  task automatic set_req(input logic id, input logic v, input logic [31:0] a, input logic [3:0] len);
    if (id) begin
      m1_arvalid = v; m1_araddr = a; m1_arlen = len; m1_arsize = 3'd3; m1_arburst = BURST_INCR;
    end else begin
      m0_arvalid = v; m0_araddr = a; m0_arlen = len; m0_arsize = 3'd3; m0_arburst = BURST_INCR;
    end
  endtask

  task automatic present_beat(input logic id, input int b, input logic last);
    axi_rvalid = 1'b1;
    axi_rdata  = pat(id, b);
    axi_rlast  = last;
    axi_rid    = id;
    axi_rresp  = RESP_OKAY;
  endtask

  task automatic run_burst(input vec_t v, input string tag);
    logic [31:0] ea;
    ea = v.exp_id ? v.a1 : v.a0;
    set_req(1'b0, v.v0, v.a0, v.len);
    set_req(1'b1, v.v1, v.a1, v.len);
    #1;
    chk({tag, "_m0_arready"}, 64'(m0_arready), 64'(!v.exp_id));
    chk({tag, "_m1_arready"}, 64'(m1_arready), 64'(v.exp_id));
    cyc();
    m0_arvalid = 1'b0;
    m1_arvalid = 1'b0;
    #1;
    chk({tag, "_arvalid"}, 64'(axi_arvalid), 64'd1);
    chk({tag, "_arid"},    64'(axi_arid),    64'(v.exp_id));
    chk({tag, "_araddr"},  64'(axi_araddr),  64'(ea));
    chk({tag, "_arlen"},   64'(axi_arlen),   64'(v.len));
    chk({tag, "_arburst"}, 64'(axi_arburst), 64'(BURST_INCR));
    axi_arready = 1'b1;
    cyc();
    axi_arready = 1'b0;
    for (int b = 0; b <= int'(v.len); b++) begin
      present_beat(v.exp_id, b, b == int'(v.len));
      #1;
      if (v.exp_id) begin
        chk({tag, "_own_rvalid"}, 64'(m1_rvalid), 64'd1);
        chk({tag, "_own_rdata"},  m1_rdata, pat(1'b1, b));
        chk({tag, "_oth_rvalid"}, 64'(m0_rvalid), 64'd0);
      end else begin
        chk({tag, "_own_rvalid"}, 64'(m0_rvalid), 64'd1);
        chk({tag, "_own_rdata"},  m0_rdata, pat(1'b0, b));
        chk({tag, "_oth_rvalid"}, 64'(m1_rvalid), 64'd0);
      end
      cyc();
    end
    axi_rvalid = 1'b0;
    axi_rlast  = 1'b0;
    #1;
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int beats;
    cpu_reset = 1'b1;
    set_req(1'b0, 1'b0, 32'h0, 4'd0);
    set_req(1'b1, 1'b0, 32'h0, 4'd0);
    m0_rready = 1'b1; m1_rready = 1'b1;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = '0;
    axi_rresp = RESP_OKAY; axi_rlast = 1'b0; axi_rid = 1'b0;

    vecs[0] = '{1'b1, 1'b1, 4'd0, 1'b0, 32'h0000_1100, 32'h0000_8100};
    vecs[1] = '{1'b1, 1'b1, 4'd0, 1'b1, 32'h0000_1200, 32'h0000_8200};
    vecs[2] = '{1'b1, 1'b1, 4'd0, 1'b0, 32'h0000_1300, 32'h0000_8300};
    vecs[3] = '{1'b1, 1'b1, 4'd0, 1'b1, 32'h0000_1400, 32'h0000_8400};
    vecs[4] = '{1'b1, 1'b0, 4'd3, 1'b0, 32'h0000_1000, 32'h0000_8500};
    vecs[5] = '{1'b0, 1'b1, 4'd1, 1'b1, 32'h0000_1600, 32'h0000_8600};
    vecs[6] = '{1'b1, 1'b1, 4'd2, 1'b0, 32'h0000_1700, 32'h0000_8700};
    vecs[7] = '{1'b1, 1'b1, 4'd0, 1'b1, 32'h0000_1800, 32'h0000_8800};

    cyc(); cyc();
    chk("rst_busy",      64'(busy),        64'd0);
    chk("rst_arvalid",   64'(axi_arvalid), 64'd0);
    chk("rst_rready",    64'(axi_rready),  64'd0);
    chk("rst_m0_rvalid", 64'(m0_rvalid),   64'd0);
    chk("rst_m1_rlast",  64'(m1_rlast),    64'd0);
    chk("rst_araddr",    64'(axi_araddr),  64'd0);
    chk("rst_proto_err", 64'(proto_err),   64'd0);
    cpu_reset = 1'b0;
    #1;

    for (int i = 0; i < 8; i++) begin
      run_burst(vecs[i], $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_proto_err", i), 64'(proto_err), 64'd0);
    end

    // AR held off five cycles; m1 arrives mid-wait and must wait for m0's burst.
    set_req(1'b0, 1'b1, 32'h0000_2000, 4'd1);
    #1;
    chk("stall_grant_m0", 64'(m0_arready), 64'd1);
    cyc();
    m0_arvalid = 1'b0;
    for (int w = 0; w < 5; w++) begin
      if (w == 2) set_req(1'b1, 1'b1, 32'h0000_3000, 4'd7);
      #1;
      chk("stall_arvalid",   64'(axi_arvalid), 64'd1);
      chk("stall_araddr",    64'(axi_araddr),  64'h2000);
      chk("stall_arlen",     64'(axi_arlen),   64'd1);
      chk("stall_m0_arrdy",  64'(m0_arready),  64'd0);
      chk("stall_m1_arrdy",  64'(m1_arready),  64'd0);
      cyc();
    end
    axi_arready = 1'b1;
    cyc();
    axi_arready = 1'b0;
    present_beat(1'b0, 0, 1'b0);
    #1;
    chk("stall_data_m1_arrdy", 64'(m1_arready), 64'd0);
    cyc();
    present_beat(1'b0, 1, 1'b1);
    cyc();
    axi_rvalid = 1'b0; axi_rlast = 1'b0;
    #1;
    chk("stall_m1_granted", 64'(m1_arready), 64'd1);
    chk("stall_m0_idle",    64'(m0_arready), 64'd0);

    // m1 burst of 8 with its rready toggling every cycle.
    cyc();
    m1_arvalid = 1'b0;
    #1;
    chk("bp_arid",  64'(axi_arid),  64'd1);
    chk("bp_arlen", 64'(axi_arlen), 64'd7);
    axi_arready = 1'b1;
    cyc();
    axi_arready = 1'b0;
    beats = 0;
    for (int i = 0; i < 40 && beats < 8; i++) begin
      m1_rready = (i % 2 == 0);
      present_beat(1'b1, beats, beats == 7);
      #1;
      chk("bp_rready",    64'(axi_rready), 64'(m1_rready));
      chk("bp_m0_rvalid", 64'(m0_rvalid),  64'd0);
      chk("bp_m1_rvalid", 64'(m1_rvalid),  64'd1);
      chk("bp_m1_rdata",  m1_rdata,        pat(1'b1, beats));
      if (m1_rready) beats++;
      cyc();
    end
    axi_rvalid = 1'b0; axi_rlast = 1'b0; m1_rready = 1'b1;
    #1;
    chk("bp_busy_end",   64'(busy),      64'd0);
    chk("bp_proto_err",  64'(proto_err), 64'd0);

    // Early rlast on beat 2 of a 4-beat burst.
    set_req(1'b0, 1'b1, 32'h0000_4000, 4'd3);
    cyc();
    m0_arvalid = 1'b0;
    axi_arready = 1'b1;
    cyc();
    axi_arready = 1'b0;
    present_beat(1'b0, 0, 1'b0);
    #1;
    chk("err_beat0_clean", 64'(proto_err), 64'd0);
    cyc();
    present_beat(1'b0, 1, 1'b1);
    axi_rresp = RESP_SLVERR;
    #1;
    chk("err_rresp", 64'(m0_rresp), 64'(RESP_SLVERR));
    chk("err_rlast", 64'(m0_rlast), 64'd1);
    cyc();
    axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rresp = RESP_OKAY;
    #1;
    chk("err_set",  64'(proto_err), 64'd1);
    chk("err_idle", 64'(busy),      64'd0);
    run_burst('{1'b0, 1'b1, 4'd0, 1'b1, 32'h0000_4100, 32'h0000_9000}, "err_next1");
    run_burst('{1'b1, 1'b0, 4'd0, 1'b0, 32'h0000_4200, 32'h0000_9100}, "err_next0");
    chk("err_sticky", 64'(proto_err), 64'd1);

    // Reset during beat 2 of an m1 burst; pointer currently favours m1.
    set_req(1'b1, 1'b1, 32'h0000_5000, 4'd3);
    #1;
    chk("rr_grant_m1", 64'(m1_arready), 64'd1);
    cyc();
    m1_arvalid = 1'b0;
    axi_arready = 1'b1;
    cyc();
    axi_arready = 1'b0;
    present_beat(1'b1, 0, 1'b0);
    cyc();
    present_beat(1'b1, 1, 1'b0);
    #1;
    cpu_reset = 1'b1;
    #1;
    chk("mrst_busy",      64'(busy),        64'd0);
    chk("mrst_rready",    64'(axi_rready),  64'd0);
    chk("mrst_m1_rvalid", 64'(m1_rvalid),   64'd0);
    chk("mrst_arvalid",   64'(axi_arvalid), 64'd0);
    chk("mrst_araddr",    64'(axi_araddr),  64'd0);
    chk("mrst_arlen",     64'(axi_arlen),   64'd0);
    chk("mrst_proto_err", 64'(proto_err),   64'd0);
    cyc();
    cpu_reset = 1'b0;
    #1;
    chk("mrst_stray_rready", 64'(axi_rready), 64'd0);
    chk("mrst_stray_rvalid", 64'(m1_rvalid),  64'd0);
    cyc();
    axi_rvalid = 1'b0;
    #1;
    chk("mrst_stray_err", 64'(proto_err), 64'd1);
    set_req(1'b0, 1'b1, 32'h0000_6000, 4'd0);
    set_req(1'b1, 1'b1, 32'h0000_7000, 4'd0);
    #1;
    chk("mrst_prio_m0", 64'(m0_arready), 64'd1);
    chk("mrst_prio_m1", 64'(m1_arready), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
